// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result valid-ready bundle for the nibble-serial adder
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  modport master (
    output in_valid, a, b, carry_in, op_sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );
  modport slave (
    input  in_valid, a, b, carry_in, op_sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit add/subtract computed one nibble per clock through a single 4-bit adder
module four_bit_full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0, carry_in};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [W-1:0]  op_a, op_b, result;
  logic          carry, carry_out, overflow;
  logic [3:0]    fa_sum;
  logic          fa_co;
  logic          last;
  assign last = idx == IW'(NIBBLES - 1);
  four_bit_full_adder u_fa (
    .a         (op_a[{idx, 2'b00} +: 4]),
    .b         (op_b[{idx, 2'b00} +: 4]),
    .carry_in  (carry),
    .sum       (fa_sum),
    .carry_out (fa_co)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: accept in IDLE, step through nibbles in RUN, hold result until consumed
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : (bus.out_ready ? IDLE : DONE);
  end
  // datapath: latch operands on accept, then ripple one nibble per edge with the carry held in a register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      op_a  <= bus.a;
      op_b  <= bus.op_sub ? ~bus.b : bus.b;
      carry <= bus.op_sub | bus.carry_in;
      idx   <= '0;
    end else if (state == RUN) begin
      result[{idx, 2'b00} +: 4] <= fa_sum;
      carry <= fa_co;
      idx   <= idx + 1'b1;
      if (last) begin
        carry_out <= fa_co;
        overflow  <= (op_a[W-1] == op_b[W-1]) && (fa_sum[3] != op_a[W-1]);
      end
    end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.sum       = result;
  assign bus.carry_out = carry_out;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed-vector bench for the nibble-serial adder
module tb_nibble_serial_adder;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int edges;
  nibble_serial_adder_if #(.NIBBLES(N)) bus ();
  nibble_serial_adder #(.NIBBLES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub);
    bus.a = a; bus.b = b; bus.carry_in = ci; bus.op_sub = sub; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = a ^ b; bus.carry_in = ~ci; bus.op_sub = ~sub;
  endtask

  task automatic wait_done(output int e);
    e = 1;
    while (bus.out_valid !== 1'b1 && e < 40) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.sum !== 16'h0) begin n_fail++; $display("FAIL reset_sum got %h want 0000", bus.sum); end
    n_checks++; if ({bus.carry_out, bus.overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {bus.carry_out, bus.overflow}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ripple();
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(edges);
    n_checks++; if (edges != N + 1) begin n_fail++; $display("FAIL ripple_latency got %0d want %0d", edges, N + 1); end
    n_checks++; if (bus.sum !== 16'h0000) begin n_fail++; $display("FAIL ripple_sum got %h want 0000", bus.sum); end
    n_checks++; if ({bus.carry_out, bus.overflow} !== 2'b10) begin n_fail++; $display("FAIL ripple_flags got %b want 10", {bus.carry_out, bus.overflow}); end
    finish_op();
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ripple_idle got %b%b want 10", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_overflow();
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(edges);
    n_checks++; if (edges != N + 1) begin n_fail++; $display("FAIL ovf_latency got %0d want %0d", edges, N + 1); end
    n_checks++; if (bus.sum !== 16'h8000) begin n_fail++; $display("FAIL ovf_sum got %h want 8000", bus.sum); end
    n_checks++; if ({bus.carry_out, bus.overflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_flags got %b want 01", {bus.carry_out, bus.overflow}); end
    finish_op();
    start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_done(edges);
    n_checks++; if (bus.sum !== 16'h5556) begin n_fail++; $display("FAIL cin_sum got %h want 5556", bus.sum); end
    n_checks++; if ({bus.carry_out, bus.overflow} !== 2'b00) begin n_fail++; $display("FAIL cin_flags got %b want 00", {bus.carry_out, bus.overflow}); end
    finish_op();
  endtask

  task automatic test_sub();
    start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done(edges);
    n_checks++; if (bus.sum !== 16'hFFFE) begin n_fail++; $display("FAIL sub_borrow_sum got %h want fffe", bus.sum); end
    n_checks++; if ({bus.carry_out, bus.overflow} !== 2'b00) begin n_fail++; $display("FAIL sub_borrow_flags got %b want 00", {bus.carry_out, bus.overflow}); end
    finish_op();
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(edges);
    n_checks++; if (bus.sum !== 16'h7FFF) begin n_fail++; $display("FAIL sub_ovf_sum got %h want 7fff", bus.sum); end
    n_checks++; if ({bus.carry_out, bus.overflow} !== 2'b11) begin n_fail++; $display("FAIL sub_ovf_flags got %b want 11", {bus.carry_out, bus.overflow}); end
    finish_op();
  endtask

  task automatic test_backpressure();
    start_op(16'h0102, 16'h0304, 1'b0, 1'b0);
    wait_done(edges);
    for (int i = 0; i < 3; i++) begin
      bus.a = 16'h1111; bus.b = 16'h1111; bus.in_valid = (i == 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_%0d got valid/ready %b%b want 10", i, bus.out_valid, bus.in_ready); end
      n_checks++; if ({bus.sum, bus.carry_out} !== {16'h0406, 1'b0}) begin n_fail++; $display("FAIL bp_data_%0d got %h/%b want 0406/0", i, bus.sum, bus.carry_out); end
    end
    finish_op();
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got ready/valid %b%b want 10", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_hs got valid/ready %b%b want 01", bus.out_valid, bus.in_ready); end
    n_checks++; if ({bus.sum, bus.carry_out, bus.overflow} !== 18'h0) begin n_fail++; $display("FAIL abort_data got %h/%b%b want 0000/00", bus.sum, bus.carry_out, bus.overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done(edges);
    n_checks++; if (edges != N + 1) begin n_fail++; $display("FAIL post_reset_latency got %0d want %0d", edges, N + 1); end
    n_checks++; if ({bus.sum, bus.carry_out, bus.overflow} !== {16'h0002, 2'b00}) begin n_fail++; $display("FAIL post_reset_result got %h/%b%b want 0002/00", bus.sum, bus.carry_out, bus.overflow); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3] = '{16'h1111, 16'h00FF, 16'hFFF0};
    logic [15:0] vb [3] = '{16'h2222, 16'h0F01, 16'h0020};
    logic [15:0] vs [3] = '{16'h3333, 16'h1000, 16'h0010};
    int got = 0;
    bus.a = va[0]; bus.b = vb[0]; bus.carry_in = 1'b0; bus.op_sub = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      if (t == 1 || t == 7) begin bus.a = va[t / 6 + 1]; bus.b = vb[t / 6 + 1]; end
      if (t == 13) bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== (t % 6 == 5)) begin n_fail++; $display("FAIL b2b_valid_t%0d got %b want %b", t, bus.out_valid, t % 6 == 5); end
      n_checks++; if (bus.in_ready !== (t % 6 == 0)) begin n_fail++; $display("FAIL b2b_ready_t%0d got %b want %b", t, bus.in_ready, t % 6 == 0); end
      if (bus.out_valid === 1'b1 && got < 3) begin
        n_checks++; if (bus.sum !== vs[got]) begin n_fail++; $display("FAIL b2b_sum_%0d got %h want %h", got, bus.sum, vs[got]); end
        got++;
      end
    end
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", got); end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    bus.carry_in = 1'b0; bus.op_sub = 1'b0;
    test_reset();
    test_ripple();
    test_overflow();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle W-bit add/subtract unit that drives one four_bit_full_adder instance one nibble per clock, least-significant nibble first, with the ripple carry held in a register between nibbles.
- Sits between the operand source (valid/ready producer) and the result consumer (valid/ready sink).
- Trades latency for area: one 4-bit adder serves any word width.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; W = 4*NIBBLES (default 16); legal range 2..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands (1 only in IDLE)
a  input  W  operand A
b  input  W  operand B
carry_in  input  1  carry into nibble 0 (add mode only)
op_sub  input  1  0: A+B+carry_in; 1: A-B (two's complement)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  W  result word
carry_out  output  1  carry out of top nibble (sub: 1 = no borrow)
overflow  output  1  signed overflow of the W-bit operation

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: state=IDLE; nibble index=0; carry reg=0; operand regs=0; sum=0; carry_out=0; overflow=0; out_valid=0. in_ready is decoded from state, so it reads 1 during and after reset.
- States:
  - IDLE: in_ready=1, out_valid=0. On a rising edge with in_valid=1:
    - latch a into opA.
    - latch b_eff into opB: b_eff = op_sub ? ~b : b.
    - load the carry reg with op_sub ? 1 : carry_in.
    - set index=0 and go to RUN.
    - in_valid=0 leaves IDLE unchanged.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - feed opA[4i+3:4i], opB[4i+3:4i] and the carry reg to the adder.
    - write the adder sum into result bits [4i+3:4i].
    - load the adder carry_out into the carry reg.
    - index++.
    - The edge processing i=NIBBLES-1 also loads carry_out, computes overflow and goes to DONE.
  - DONE: out_valid=1; sum, carry_out and overflow are stable. An edge with out_ready=1 returns to IDLE. out_ready=0 holds DONE indefinitely.
- Overflow = (opA[W-1] == opB[W-1]) && (result[W-1] != opA[W-1]), where opB is the already-inverted operand in sub mode.
- Latency: out_valid rises exactly NIBBLES+1 edges after the accepting edge (5 for the default). Throughput is one operation per NIBBLES+2 cycles minimum. There is no overlap: in_valid is ignored outside IDLE.
- After the out handshake, sum, carry_out and overflow keep their last values until the next operation completes. They are meaningful only while out_valid=1.
- Arithmetic is modulo 2^W. In sub mode carry_in is ignored.
- Operand inputs are sampled only on the accepting edge. Changes to a, b, op_sub or carry_in afterwards have no effect.
- rst_n asserted in RUN or DONE aborts the operation immediately. The partial result is discarded, all outputs go to their reset values, and no out_valid is produced.
- A fresh in_valid in the same cycle as the DONE->IDLE handshake is not accepted. It is accepted on the following edge if still asserted.
- One four_bit_full_adder instance only. No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Test Plan:
1. Add with full carry ripple (NIBBLES=4): a=0xFFFF, b=0x0001, carry_in=0, op_sub=0 -> after 5 edges out_valid=1, sum=0x0000, carry_out=1, overflow=0.
2. Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, carry_out=0, overflow=1. Then a=0x1234, b=0x4321, carry_in=1 -> sum=0x5556, carry_out=0, overflow=0.
3. Subtract with borrow: a=0x0005, b=0x0007, op_sub=1, carry_in=1 (must be ignored) -> sum=0xFFFE, carry_out=0, overflow=0. Also a=0x8000, b=0x0001, op_sub=1 -> sum=0x7FFF, carry_out=1, overflow=1.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid -> out_valid, sum and carry_out stay stable, in_ready=0, and a pulsed in_valid is ignored. Raising out_ready gives IDLE on the next edge and in_ready=1.
5. Reset mid-operation: drop rst_n for part of a cycle after 2 nibbles of a=0xFFFF+0x0001 -> out_valid=0, sum=0, carry_out=0 and in_ready=1 immediately (asynchronous). A new operation 0x0001+0x0001 then gives sum=0x0002 with no residual carry.
6. Back-to-back operations with in_valid and out_ready held at 1 -> each result appears NIBBLES+1 edges after its accept, with a one-cycle IDLE gap between operations and no lost or duplicated results.
